// File: rtl/dis7seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package dis7seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  // Hex digit to {g,f,e,d,c,b,a} in active-high form; entry i is digit i.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Blink phase encoding.
  localparam logic PHASE_ON  = 1'b0;
  localparam logic PHASE_OFF = 1'b1;

  // Counter width able to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Map active-high segments onto the pin polarity.
  function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] seg_hi,
                                                 input logic act_low);
    return act_low ? ~seg_hi : seg_hi;
  endfunction

  // Map an active-high single pin onto the pin polarity.
  function automatic logic bit_drive(input logic b, input logic act_low);
    return b ^ act_low;
  endfunction

endpackage

// File: rtl/dis7seg_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern.
module dis7seg_hex_decoder
  import dis7seg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg_c = HEX_SEG_TABLE[nibble];
  end

endmodule

// File: rtl/dis7seg_scan_driver.sv
// Time-multiplexed hex display driver with blank, blink, dp and dead time.
module dis7seg_scan_driver
  import dis7seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEAD_CYCLES  = 500,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          DIG_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int unsigned SLOT_W  = cnt_width(SCAN_DIV);
  localparam int unsigned IDX_W   = cnt_width(NUM_DIGITS);
  localparam int unsigned BLINK_W = cnt_width(BLINK_FRAMES + 1);

  localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [SEG_W-1:0]      SEG_IDLE   = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_IDLE    = SEG_ACT_LOW;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE   = DIG_ACT_LOW ? '1 : '0;

  logic [SLOT_W-1:0]  slot_cnt;
  logic [IDX_W-1:0]   dig_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic [NUM_DIGITS-1:0][NIB_W-1:0] digit_pend, digit_sh;
  logic [NUM_DIGITS-1:0]            dp_pend, dp_sh;
  logic [NUM_DIGITS-1:0]            blank_pend, blank_sh;
  logic [NUM_DIGITS-1:0]            blink_pend, blink_sh;
  logic                             commit;

  logic                  slot_wrap_c;
  logic                  frame_end_c;
  logic                  in_dead_c;
  logic                  dark_c;
  logic [NUM_DIGITS-1:0] onehot_c;
  logic [SEG_W-1:0]      seg_hi_c;
  logic [SEG_W-1:0]      seg_nxt_c;
  logic                  dp_nxt_c;
  logic [NUM_DIGITS-1:0] dig_nxt_c;

  assign slot_wrap_c = (slot_cnt == SLOT_LAST);
  assign frame_end_c = slot_wrap_c && (dig_idx == IDX_LAST);

  // Slot counter and digit index: one slot per digit, wrapping each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_wrap_c) begin
      slot_cnt <= '0;
      dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // Blink phase toggles every BLINK_FRAMES frame boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= PHASE_ON;
    end else if (frame_end_c) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Pending capture on load; shadow only updates at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_pend <= '0;
      dp_pend    <= '0;
      blank_pend <= '1;
      blink_pend <= '0;
      commit     <= 1'b0;
      digit_sh   <= '0;
      dp_sh      <= '0;
      blank_sh   <= '1;
      blink_sh   <= '0;
    end else begin
      if (load) begin
        digit_pend <= digit_data;
        dp_pend    <= dp_in;
        blank_pend <= blank_in;
        blink_pend <= blink_en;
      end
      if (frame_end_c) begin
        commit <= 1'b0;
        if (load) begin
          digit_sh <= digit_data;
          dp_sh    <= dp_in;
          blank_sh <= blank_in;
          blink_sh <= blink_en;
        end else if (commit) begin
          digit_sh <= digit_pend;
          dp_sh    <= dp_pend;
          blank_sh <= blank_pend;
          blink_sh <= blink_pend;
        end
      end else if (load) begin
        commit <= 1'b1;
      end
    end
  end

  dis7seg_hex_decoder u_dec (
    .nibble (digit_sh[dig_idx]),
    .seg_c  (seg_hi_c)
  );

  assign in_dead_c = (32'(slot_cnt) < DEAD_CYCLES);
  assign dark_c    = blank_sh[dig_idx] | (blink_sh[dig_idx] & (blink_phase == PHASE_OFF));
  assign onehot_c  = NUM_DIGITS'(1) << dig_idx;

  // Next output values from the current scan state.
  always_comb begin
    seg_nxt_c = SEG_IDLE;
    dp_nxt_c  = DP_IDLE;
    dig_nxt_c = DIG_IDLE;
    if (!in_dead_c) begin
      dig_nxt_c = DIG_ACT_LOW ? ~onehot_c : onehot_c;
      if (!dark_c) begin
        seg_nxt_c = seg_drive(seg_hi_c, SEG_ACT_LOW);
        dp_nxt_c  = bit_drive(dp_sh[dig_idx], SEG_ACT_LOW);
      end
    end
  end

  // Registered pin stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= SEG_IDLE;
      dp_out     <= DP_IDLE;
      dig_sel    <= DIG_IDLE;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_nxt_c;
      dp_out     <= dp_nxt_c;
      dig_sel    <= dig_nxt_c;
      frame_done <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_dis7seg_scan_driver.sv
// Directed bench for dis7seg_scan_driver (4 digits, 8-cycle slots, 2 dead, blink 2 frames).
module tb_dis7seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  blink_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  dis7seg_scan_driver #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (8),
    .DEAD_CYCLES  (2),
    .BLINK_FRAMES (2),
    .SEG_ACT_LOW  (1'b1),
    .DIG_ACT_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digit_data (digit_data),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .blink_en   (blink_en),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // One clock; outputs are examined 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  // Advance until the outputs show frame f, position p (tick t shows position t-1).
  task automatic run_to(input int f, input int p);
    int target;
    target = f * 32 + p + 1;
    if (t > target) begin
      total++;
      bad++;
      $error("FAIL run_to f=%0d p=%0d observed tick=%0d expected<=%0d", f, p, t, target);
    end
    while (t < target) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (tick %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [6:0] s, input logic d,
                          input logic [3:0] g);
    chk({tag, ".seg"}, 16'(seg_out), 16'(s));
    chk({tag, ".dp"},  16'(dp_out),  16'(d));
    chk({tag, ".dig"}, 16'(dig_sel), 16'(g));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [3:0] bk);
    digit_data = d;
    dp_in      = dp;
    blank_in   = bl;
    blink_en   = bk;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; digit_data = '0; dp_in = '0; blank_in = '0; blink_en = '0;

    // Reset held for three cycles.
    tick(); tick(); tick();
    chk_pins("reset", 7'h7F, 1'b1, 4'hF);
    chk("reset.fd", 16'(frame_done), 16'h0);
    rst = 1'b0;
    t = 0;

    // Frame 0: nothing committed yet, digits scan but stay dark.
    run_to(0, 2);  chk_pins("f0p2", 7'h7F, 1'b1, 4'hE);
    run_to(0, 5);  do_load(16'h3A90, 4'h0, 4'h0, 4'h0);
    run_to(0, 10); chk_pins("f0p10", 7'h7F, 1'b1, 4'hD);
    run_to(0, 30); chk("f0p30.fd", 16'(frame_done), 16'h0);
    run_to(0, 31); chk("f0p31.fd", 16'(frame_done), 16'h1);

    // Frame 1: 3A90 shows, dead time at slot start.
    run_to(1, 0);  chk_pins("f1p0", 7'h7F, 1'b1, 4'hF);
    run_to(1, 1);  chk_pins("f1p1", 7'h7F, 1'b1, 4'hF);
    chk("f1p1.fd", 16'(frame_done), 16'h0);
    run_to(1, 2);  chk_pins("f1p2", 7'h40, 1'b1, 4'hE);
    run_to(1, 8);  chk("f1p8.dig", 16'(dig_sel), 16'hF);
    run_to(1, 10); chk_pins("f1p10", 7'h10, 1'b1, 4'hD);
    run_to(1, 12); do_load(16'h1111, 4'h0, 4'h0, 4'h0);
    run_to(1, 18); chk_pins("f1p18", 7'h08, 1'b1, 4'hB);
    run_to(1, 26); chk_pins("f1p26", 7'h30, 1'b1, 4'h7);
    run_to(1, 31); chk("f1p31.fd", 16'(frame_done), 16'h1);

    // Frame 2: 1111; load exactly on the boundary cycle.
    run_to(2, 2);  chk_pins("f2p2", 7'h79, 1'b1, 4'hE);
    run_to(2, 26); chk_pins("f2p26", 7'h79, 1'b1, 4'h7);
    run_to(2, 30); do_load(16'h8888, 4'h0, 4'h0, 4'h0);
    chk("f2p31.fd", 16'(frame_done), 16'h1);

    // Frame 3: boundary load visible at once; then blank/dp load mid-frame.
    run_to(3, 2);  chk_pins("f3p2", 7'h00, 1'b1, 4'hE);
    run_to(3, 12); do_load(16'h3A90, 4'b0001, 4'b0100, 4'h0);
    run_to(3, 18); chk_pins("f3p18", 7'h00, 1'b1, 4'hB);

    // Frame 4: digit 0 dp on, digit 2 blanked.
    run_to(4, 2);  chk_pins("f4p2", 7'h40, 1'b0, 4'hE);
    run_to(4, 10); chk_pins("f4p10", 7'h10, 1'b1, 4'hD);
    run_to(4, 18); chk_pins("f4p18", 7'h7F, 1'b1, 4'hB);
    run_to(4, 20); do_load(16'h3A90, 4'h0, 4'h0, 4'b1000);
    run_to(4, 26); chk_pins("f4p26", 7'h30, 1'b1, 4'h7);

    // Blink on digit 3: frames 4,5 lit, 6,7 dark, 8 lit.
    run_to(5, 18); chk_pins("f5p18", 7'h08, 1'b1, 4'hB);
    run_to(5, 26); chk_pins("f5p26", 7'h30, 1'b1, 4'h7);
    run_to(6, 2);  chk_pins("f6p2", 7'h40, 1'b1, 4'hE);
    run_to(6, 26); chk_pins("f6p26", 7'h7F, 1'b1, 4'h7);
    run_to(7, 10); chk_pins("f7p10", 7'h10, 1'b1, 4'hD);
    run_to(7, 26); chk_pins("f7p26", 7'h7F, 1'b1, 4'h7);
    run_to(8, 26); chk_pins("f8p26", 7'h30, 1'b1, 4'h7);

    // Frame 9: pending load, then reset at digit 2 counter 5.
    run_to(9, 12); do_load(16'h1111, 4'h0, 4'h0, 4'h0);
    run_to(9, 20);
    rst = 1'b1;
    tick();
    chk_pins("midrst", 7'h7F, 1'b1, 4'hF);
    chk("midrst.fd", 16'(frame_done), 16'h0);
    rst = 1'b0;
    t = 0;
    tick();
    chk_pins("post0", 7'h7F, 1'b1, 4'hF);
    run_to(0, 2);  chk_pins("post2", 7'h7F, 1'b1, 4'hE);
    run_to(0, 31); chk("post31.fd", 16'(frame_done), 16'h1);
    run_to(1, 2);  chk_pins("post_f1p2", 7'h7F, 1'b1, 4'hE);
    run_to(1, 26); chk_pins("post_f1p26", 7'h7F, 1'b1, 4'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
